fp_mult_unpack: RTL and testbench

Input-side operand decoder for the floating-point multiplier pipeline; the counterpart of the stage-5 round/pack stage. Accepts one packed IEEE-754 operand per handshake and splits it into sign, biased exponent and mantissa with explicit hidden bit. Subnormals are normalized by an iterative one-bit-per-cycle shifter. NaN, infinity and zero are classified. The result is presented on a valid/ready output so downstream multiplier stages see only normalized significands plus special flags.

---
 rtl/fp_mult_unpack.sv | 120 ++++++++++++
 tb/tb_fp_mult_unpack.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_unpack.sv
// Input-side operand decoder for the FP multiplier: splits a packed IEEE-754 operand
// into sign / biased exponent / explicit-hidden-bit significand, normalizing subnormals.
module fp_mult_unpack #(
   parameter int EXP_LEN  = 8,
   parameter int MANT_LEN = 23,
   localparam int FP_LEN  = 1 + EXP_LEN + MANT_LEN
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [FP_LEN-1:0]    in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 sign,
   output logic [EXP_LEN+1:0]   exp,
   output logic [MANT_LEN:0]    mant,
   output logic                 nan,
   output logic                 inf,
   output logic                 zero
);

   typedef enum logic [1:0] {IDLE, NORM, VALID} state_t;

   localparam logic [EXP_LEN+1:0] EXP_ONE = {{(EXP_LEN+1){1'b0}}, 1'b1};
   localparam logic [EXP_LEN-1:0] FIELD_MAX = '1;

   state_t               state_q, state_d;
   logic                 sign_q, sign_d;
   logic [EXP_LEN+1:0]   exp_q, exp_d;
   logic [MANT_LEN:0]    mant_q, mant_d;
   logic                 nan_q, nan_d;
   logic                 inf_q, inf_d;
   logic                 zero_q, zero_d;

   logic                 accept;
   logic [EXP_LEN-1:0]   field;
   logic [MANT_LEN-1:0]  frac;

   assign field     = in_data[FP_LEN-2 -: EXP_LEN];
   assign frac      = in_data[MANT_LEN-1:0];
   assign in_ready  = (state_q == IDLE) || (state_q == VALID && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == VALID);

   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      exp_d   = exp_q;
      mant_d  = mant_q;
      nan_d   = nan_q;
      inf_d   = inf_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE, VALID: begin
            if (accept) begin
               sign_d  = in_data[FP_LEN-1];
               nan_d   = 1'b0;
               inf_d   = 1'b0;
               zero_d  = 1'b0;
               state_d = VALID;
               if (field == FIELD_MAX) begin
                  exp_d  = {2'b00, FIELD_MAX};
                  mant_d = {1'b1, frac};
                  nan_d  = (frac != '0);
                  inf_d  = (frac == '0);
               end else if (field == '0 && frac == '0) begin
                  exp_d  = '0;
                  mant_d = '0;
                  zero_d = 1'b1;
               end else if (field == '0) begin
                  // subnormal: start at exp 1 and let NORM walk the leading one up
                  exp_d   = EXP_ONE;
                  mant_d  = {1'b0, frac};
                  state_d = NORM;
               end else begin
                  exp_d  = {2'b00, field};
                  mant_d = {1'b1, frac};
               end
            end else if (state_q == VALID && out_ready) begin
               state_d = IDLE;
            end
         end
         NORM: begin
            mant_d = {mant_q[MANT_LEN-1:0], 1'b0};
            exp_d  = exp_q - EXP_ONE;
            if (mant_q[MANT_LEN-1]) state_d = VALID;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         mant_q  <= '0;
         nan_q   <= 1'b0;
         inf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         mant_q  <= mant_d;
         nan_q   <= nan_d;
         inf_q   <= inf_d;
         zero_q  <= zero_d;
      end
   end

   assign sign = sign_q;
   assign exp  = exp_q;
   assign mant = mant_q;
   assign nan  = nan_q;
   assign inf  = inf_q;
   assign zero = zero_q;

endmodule

// File: tb/tb_fp_mult_unpack.sv
// Randomized + directed bench for fp_mult_unpack (FP32) against a value-level decode model.
module tb_fp_mult_unpack;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_data;
   logic        sign, nan, inf, zero;
   logic [9:0]  exp;
   logic [23:0] mant;

   fp_mult_unpack #(.EXP_LEN(8), .MANT_LEN(23)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .sign(sign), .exp(exp), .mant(mant),
      .nan(nan), .inf(inf), .zero(zero));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [36:0] sb[$];
   logic        hold_pend = 1'b0;
   logic [37:0] held;
   logic        s_ov, s_ir, s_acc;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, want);
      end
   endtask

   // {sign, exp[9:0], mant[23:0], nan, inf, zero} from the IEEE value rules
   function automatic logic [36:0] ref_decode(input logic [31:0] d);
      int e, f, ex, p, s;
      logic [23:0] m;
      logic n, i, z;
      e = int'(d[30:23]);
      f = int'(d[22:0]);
      n = 0; i = 0; z = 0;
      if (e == 255) begin
         ex = 255; m = 24'(32'h800000 | f); n = (f != 0); i = (f == 0);
      end else if (e == 0 && f == 0) begin
         ex = 0; m = 0; z = 1;
      end else if (e == 0) begin
         p = 0;
         for (int b = 0; b < 23; b++) if ((f >> b) & 1) p = b;
         s = 23 - p;
         ex = 1 - s;
         m = 24'(f << s);
      end else begin
         ex = e; m = 24'(32'h800000 | f);
      end
      return {d[31], 10'(ex), m, n, i, z};
   endfunction

   function automatic logic [37:0] outs();
      return {out_valid, sign, exp, mant, nan, inf, zero};
   endfunction

   // one clock: drive at negedge, sample 1ns later, then advance to the next negedge
   task automatic cyc(input logic v, input logic [31:0] d, input logic rdy);
      logic [37:0] o;
      in_valid = v; in_data = d; out_ready = rdy;
      #1;
      o = outs();
      s_ov = out_valid; s_ir = in_ready; s_acc = v && in_ready;
      if (hold_pend) chk("hold", 64'(o), 64'(held));
      if (out_valid && rdy) begin
         if (sb.size() == 0) chk("spurious_out", 64'(1), 64'(0));
         else chk("data", 64'(o[36:0]), 64'(sb.pop_front()));
      end
      if (v && in_ready) sb.push_back(ref_decode(d));
      hold_pend = out_valid && !rdy;
      held = o;
      @(posedge clk); @(negedge clk);
   endtask

   // hold in_valid until accepted, random out_ready
   task automatic push(input logic [31:0] d);
      int n = 0;
      do begin
         cyc(1'b1, d, 1'($urandom_range(0, 1)));
         n++;
      end while (!s_acc && n < 60);
      if (!s_acc) chk("push_timeout", 64'(0), 64'(1));
   endtask

   // from idle: accept d, count bubble cycles until out_valid, then consume it
   task automatic send_wait(input logic [31:0] d, input int lat, input string tag);
      int n = 0;
      hold_pend = 1'b0;
      cyc(1'b1, d, 1'b0);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      while (!out_valid && n < 40) begin
         chk({tag, "_rdy_in_norm"}, 64'(in_ready), 64'(0));
         n++;
         @(posedge clk); @(negedge clk); #1;
      end
      chk({tag, "_lat"}, 64'(n), 64'(lat));
      #1;
      cyc(1'b0, 32'h0, 1'b1);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         cyc(1'b0, 32'h0, 1'b1);
         n++;
      end
      cyc(1'b0, 32'h0, 1'b1);
      chk("drain_empty", 64'(sb.size()), 64'(0));
   endtask

   function automatic logic [31:0] rnd_normal();
      return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
   endfunction

   function automatic logic [31:0] rnd_op();
      int k;
      logic [22:0] f;
      k = $urandom_range(0, 9);
      f = 23'($urandom);
      case (k)
         0: return {1'($urandom), 31'h0};
         1: return {1'($urandom), 8'hFF, 23'h0};
         2: return {1'($urandom), 8'hFF, (f == 0) ? 23'h1 : f};
         3, 4: begin
            f = f >> $urandom_range(0, 22);
            return {1'($urandom), 8'h00, (f == 0) ? 23'h1 : f};
         end
         default: return rnd_normal();
      endcase
   endfunction

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
      @(negedge clk); #1;
      chk("rst_outs", 64'(outs()), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      send_wait(32'h3F800000, 0, "one");
      send_wait(32'h00000001, 23, "sub_min");
      send_wait(32'h00400000, 1, "sub_max");
      send_wait(32'hFF800000, 0, "ninf");
      send_wait(32'h7FC00001, 0, "nan");
      send_wait(32'h80000000, 0, "nzero");
      chk("sub_min_exp", 64'(ref_decode(32'h1) >> 27), 64'({1'b0, 10'h3EA}));

      // back-to-back normals, then a 3-cycle downstream stall with a pending operand
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, rnd_normal(), 1'b1);
         chk("stream_acc", 64'(s_acc), 64'(1));
         if (i > 0) chk("stream_vld", 64'(s_ov), 64'(1));
      end
      begin
         logic [31:0] pend;
         pend = rnd_normal();
         for (int i = 0; i < 3; i++) begin
            cyc(1'b1, pend, 1'b0);
            chk("stall_in_ready", 64'(s_ir), 64'(0));
            chk("stall_vld", 64'(s_ov), 64'(1));
         end
         cyc(1'b1, pend, 1'b1);
         chk("stall_resume_acc", 64'(s_acc), 64'(1));
      end
      drain();

      push(rnd_normal());
      push(32'h00000010);
      push(rnd_normal());
      drain();

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) != 0) push(rnd_op());
         else cyc(1'b0, 32'($urandom), 1'($urandom_range(0, 1)));
      end
      drain();

      // reset in the middle of normalization
      hold_pend = 1'b0;
      cyc(1'b1, 32'h00000001, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_vld", 64'(out_valid), 64'(0));
      chk("midrst_in_ready", 64'(in_ready), 64'(1));
      sb.delete();
      hold_pend = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_wait(32'h40490FDB, 0, "post_rst");
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
